// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped, read-only instruction cache in front of the
// fetch stage. Hits return the instruction combinationally in the same
// cycle. A miss raises stall, then refills one whole line from main memory
// through a request/acknowledge handshake followed by one beat per word.
//
// Ports:
//   clock        rising-edge clock
//   rst          asynchronous active-low reset
//   pc           fetch address (bits [1:0] ignored)
//   req          fetch wants an instruction this cycle
//   flush        one-cycle pulse, invalidates every line
//   instruction  instruction for pc, meaningful when req=1 and stall=0
//   stall        freeze PC and IF/ID this cycle
//   mem_req      line refill request, held until mem_ack
//   mem_addr     line-aligned refill address
//   mem_ack      memory accepted the refill request
//   mem_rvalid   one refill beat is present on mem_rdata
//   mem_rdata    refill data word
//   miss_count   saturating miss counter
module icache_fetch #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        req,
  input  logic        flush,
  output logic [31:0] instruction,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [15:0] miss_count
);

  localparam int OFF    = $clog2(WORDS);
  localparam int IDX    = $clog2(LINES);
  localparam int TAG_W  = 30 - OFF - IDX;
  localparam int LINE_W = 30 - OFF;

  typedef enum logic [1:0] {IDLE, REQ, REFILL} stateE;

  stateE              state;
  logic [LINES-1:0]   validBits;
  logic [LINE_W-1:0]  lineHi;     // latched line address without offset bits
  logic [OFF-1:0]     beatCnt;
  logic               discard;    // a flush hit this refill; do not validate it
  logic [15:0]        missCnt;

  logic [TAG_W-1:0]   tagMem  [LINES];
  logic [31:0]        dataMem [LINES*WORDS];

  logic [OFF-1:0]     pcWord;
  logic [IDX-1:0]     pcIdx;
  logic [TAG_W-1:0]   pcTag;
  logic [IDX-1:0]     fillIdx;
  logic [TAG_W-1:0]   fillTag;
  logic               hit;
  logic               beatTake;
  logic               lastBeat;
  logic               unusedPcBits;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign pcWord       = pc[OFF+1:2];
  assign pcIdx        = pc[OFF+IDX+1:OFF+2];
  assign pcTag        = pc[31:OFF+IDX+2];
  assign unusedPcBits = ^pc[1:0];

  // The refill is steered only by the latched address, never the live pc.
  assign fillIdx  = lineHi[IDX-1:0];
  assign fillTag  = lineHi[LINE_W-1:IDX];

  assign hit      = validBits[pcIdx] && (tagMem[pcIdx] == pcTag);
  assign beatTake = (state == REFILL) && mem_rvalid;
  assign lastBeat = beatTake && (beatCnt == OFF'(WORDS - 1));

  assign mem_addr   = {lineHi, {(OFF+2){1'b0}}};
  assign miss_count = missCnt;

  // Lookup result; gated by rst so a held reset reports no stall.
  always_comb begin
    instruction = '0;
    stall       = 1'b0;
    if (rst) begin
      if (state == IDLE) begin
        if (req) begin
          if (hit) instruction = dataMem[{pcIdx, pcWord}];
          else     stall       = 1'b1;
        end
      end else begin
        stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      validBits <= '0;
      lineHi    <= '0;
      beatCnt   <= '0;
      discard   <= 1'b0;
      missCnt   <= '0;
      mem_req   <= 1'b0;
    end else begin
      // A same-cycle lookup already used the old valid bits.
      if (flush) validBits <= '0;
      case (state)
        IDLE: begin
          if (req && !hit) begin
            lineHi  <= pc[31:OFF+2];
            mem_req <= 1'b1;
            missCnt <= satInc(missCnt);
            state   <= REQ;
          end
        end
        REQ: begin
          if (flush) discard <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            beatCnt <= '0;
            state   <= REFILL;
          end
        end
        REFILL: begin
          if (flush) discard <= 1'b1;
          if (mem_rvalid) begin
            beatCnt <= beatCnt + OFF'(1);
            if (lastBeat) begin
              // A flush on the final beat also suppresses validation.
              if (!discard && !flush) validBits[fillIdx] <= 1'b1;
              discard <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage is not reset; validity is tracked solely by validBits.
  always_ff @(posedge clock) begin
    if (beatTake) begin
      dataMem[{fillIdx, beatCnt}] <= mem_rdata;
      if (lastBeat) tagMem[fillIdx] <= fillTag;
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// tb_icache_fetch: directed bench for icache_fetch (LINES=16, WORDS=4).
// Inputs change 1 time unit after a rising edge; outputs are checked 2 units
// later, well away from the next edge.
module tb_icache_fetch;

  logic        clock;
  logic        rst;
  logic [31:0] pc;
  logic        req;
  logic        flush;
  logic [31:0] instruction;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [15:0] miss_count;

  int total = 0;
  int bad   = 0;

  icache_fetch #(.LINES(16), .WORDS(4)) dut (
    .clock      (clock),
    .rst        (rst),
    .pc         (pc),
    .req        (req),
    .flush      (flush),
    .instruction(instruction),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .miss_count (miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Hit lookup in IDLE: no stall, data returned in the same cycle.
  task automatic look(input logic [31:0] a, input logic [31:0] exp);
    pc  = a;
    req = 1'b1;
    #2;
    chk("hitStall", {31'b0, stall}, 32'd0);
    chk("hitInstr", instruction, exp);
    cyc();
  endtask

  // Entered in the miss cycle with pc/req already driven. Serves the refill
  // with beats d0, d0+1, d0+2, d0+3.
  task automatic refill(input logic [31:0] addr, input int ackWait, input int gap,
                        input int flushBeat, input logic [31:0] d0);
    #2;
    chk("missStall", {31'b0, stall}, 32'd1);
    chk("missReqLow", {31'b0, mem_req}, 32'd0);
    cyc();
    for (int i = 0; i < ackWait; i++) begin
      #2;
      chk("waitReq", {31'b0, mem_req}, 32'd1);
      chk("waitStall", {31'b0, stall}, 32'd1);
      cyc();
    end
    mem_ack = 1'b1;
    #2;
    chk("reqHigh", {31'b0, mem_req}, 32'd1);
    chk("reqAddr", mem_addr, addr);
    chk("reqStall", {31'b0, stall}, 32'd1);
    cyc();
    mem_ack = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        for (int g = 0; g < gap; g++) begin
          mem_rvalid = 1'b0;
          #2;
          chk("gapStall", {31'b0, stall}, 32'd1);
          chk("gapReq", {31'b0, mem_req}, 32'd0);
          cyc();
        end
      end
      mem_rvalid = 1'b1;
      mem_rdata  = d0 + b;
      flush      = (b == flushBeat);
      #2;
      chk("beatStall", {31'b0, stall}, 32'd1);
      chk("beatReq", {31'b0, mem_req}, 32'd0);
      cyc();
    end
    mem_rvalid = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc = 32'h100; req = 1'b1; flush = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #2 rst = 1'b0;
    cyc();
    cyc();
    // Reset state, with a request pending
    chk("rstStall", {31'b0, stall}, 32'd0);
    chk("rstInstr", instruction, 32'd0);
    chk("rstMemReq", {31'b0, mem_req}, 32'd0);
    chk("rstMemAddr", mem_addr, 32'd0);
    chk("rstMiss", {16'b0, miss_count}, 32'd0);
    rst = 1'b1;
    req = 1'b0;
    #2;
    chk("idleNoReqStall", {31'b0, stall}, 32'd0);
    chk("idleNoReqInstr", instruction, 32'd0);
    cyc();

    // Cold miss at 0x100, immediate ack, back-to-back beats
    pc = 32'h100; req = 1'b1;
    refill(32'h100, 0, 0, -1, 32'hA0);
    look(32'h100, 32'hA0);
    look(32'h10C, 32'hA3);
    chk("coldMissCnt", {16'b0, miss_count}, 32'd1);

    // Delayed ack and gappy beats on another line
    pc = 32'h210;
    refill(32'h210, 3, 2, -1, 32'hB0);
    look(32'h210, 32'hB0);
    look(32'h21C, 32'hB3);
    look(32'h218, 32'hB2);
    chk("gappyMissCnt", {16'b0, miss_count}, 32'd2);

    // Conflict eviction on index 0
    pc = 32'h000;
    refill(32'h000, 0, 0, -1, 32'hC0);
    look(32'h004, 32'hC1);
    pc = 32'h100;
    refill(32'h100, 0, 0, -1, 32'hD0);
    look(32'h108, 32'hD2);
    pc = 32'h000;
    refill(32'h000, 1, 0, -1, 32'hC0);
    look(32'h000, 32'hC0);
    look(32'h214, 32'hB1);
    chk("conflictMissCnt", {16'b0, miss_count}, 32'd5);

    // Flush in IDLE: same-cycle lookup uses old valid bits
    pc = 32'h100;
    refill(32'h100, 0, 0, -1, 32'hD0);
    pc = 32'h100; flush = 1'b1;
    #2;
    chk("flushSameStall", {31'b0, stall}, 32'd0);
    chk("flushSameInstr", instruction, 32'hD0);
    cyc();
    flush = 1'b0;

    // Next access misses; flush during the refill after beat 1
    refill(32'h100, 0, 0, 2, 32'hE0);
    // Discarded line: immediate re-lookup misses and re-requests 0x100
    refill(32'h100, 0, 0, -1, 32'hE0);
    look(32'h10C, 32'hE3);
    chk("flushMissCnt", {16'b0, miss_count}, 32'd8);

    // Reset mid-REFILL: 0x210 was flushed, so it misses
    pc = 32'h210;
    #2;
    chk("flushedStall", {31'b0, stall}, 32'd1);
    cyc();
    mem_ack = 1'b1;
    #2;
    chk("rr reqHigh", {31'b0, mem_req}, 32'd1);
    cyc();
    mem_ack = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hF0 + b;
      cyc();
    end
    mem_rvalid = 1'b0;
    rst = 1'b0;
    #1;
    chk("abortStall", {31'b0, stall}, 32'd0);
    chk("abortReq", {31'b0, mem_req}, 32'd0);
    chk("abortMiss", {16'b0, miss_count}, 32'd0);
    cyc();
    rst = 1'b1;
    pc = 32'h100;
    refill(32'h100, 1, 1, -1, 32'h50);
    look(32'h100, 32'h50);
    look(32'h10C, 32'h53);
    chk("postRstMissCnt", {16'b0, miss_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
Direct-mapped, read-only instruction cache directly upstream of the fetch stage. It supplies the 32-bit instruction for the current PC from a small line store. On a miss it stalls the pipeline and refills one line from main memory through a request/acknowledge plus beat-valid handshake. It is read-only: there is no write path from the pipeline, and invalidation is by flush only.

Parameters:
LINES, 16, number of cache lines; power of 2, minimum 2.
WORDS, 4, 32-bit words per line; power of 2, minimum 2.
Address split: OFF = log2(WORDS), IDX = log2(LINES).
- pc[1:0] is ignored.
- Word offset is pc[OFF+1:2].
- Index is pc[OFF+IDX+1:OFF+2].
- Tag is pc[31:OFF+IDX+2].

Ports:
clock  in  1  rising-edge clock.
rst  in  1  asynchronous, active-low reset.
pc  in  32  fetch address from the PC register.
req  in  1  fetch wants an instruction this cycle.
flush  in  1  invalidate all lines (one-cycle pulse).
instruction  out  32  instruction for pc; valid when req=1 and stall=0.
stall  out  1  freeze PC and IF_ID this cycle.
mem_req  out  1  line refill request to main memory.
mem_addr  out  32  line-aligned refill address (low OFF+2 bits zero).
mem_ack  in  1  memory accepted the request.
mem_rvalid  in  1  one refill beat is present on mem_rdata.
mem_rdata  in  32  refill data word.
miss_count  out  16  saturating count of misses.

Behaviour:
- State machine states: IDLE, REQ, REFILL.
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All valid bits are cleared.
  - mem_req=0, mem_addr=0, miss_count=0, beat counter=0.
  - instruction=0, stall=0.
  - Tag and data arrays are not reset.
- Hit in IDLE: req=1 and valid[idx] and tag[idx]==tag(pc).
  - Combinational and zero-latency: instruction=data[idx][word], stall=0.
- req=0 in IDLE: stall=0, instruction=0, no state change.
- Miss in IDLE (req=1, not a hit):
  - stall=1 combinationally in the same cycle.
  - Next edge: latch line address {pc[31:OFF+2], zeros}, move to REQ, increment miss_count (saturates at 16'hFFFF).
- REQ:
  - mem_req=1; mem_addr holds the latched address; stall=1.
  - The edge with mem_ack=1 moves to REFILL with beat counter=0. mem_req drops in the next cycle.
  - The wait for mem_ack is unbounded.
- REFILL:
  - stall=1, mem_req=0.
  - Each edge with mem_rvalid=1 writes mem_rdata into data[latched idx][counter] and increments the counter.
  - Beats arrive in word order 0..WORDS-1. mem_rvalid may have gaps.
  - On the edge that accepts beat WORDS-1: write the tag, set valid (unless the discard flag is set), clear the discard flag, go to IDLE.
  - Beats outside REFILL are ignored.
- Miss latency: with mem_ack on the first REQ cycle and back-to-back beats, the miss cycle plus 1 (REQ) plus WORDS (REFILL) gives stall high for WORDS+2 cycles. The hit is then returned in the following cycle.
- PC during a miss:
  - The pipeline holds pc while stall=1.
  - The refill always uses the latched address, never the live pc.
  - On return to IDLE, a lookup is redone with the current pc. If pc changed, the result may be a new miss.
- Flush:
  - In IDLE: all valid bits clear at the next edge. A same-cycle lookup uses the pre-flush valid bits.
  - In REQ or REFILL: clears all valid bits and sets the discard flag. The refill completes on the bus (no protocol abort) but its line is not marked valid.
- Conflict: a refill into a valid line overwrites its tag and data.
- Asynchronous reset mid-REQ or mid-REFILL: immediate abort to IDLE. Memory is responsible for dropping any outstanding beats.

Test Plan:
- Cold miss. After reset, req=1, pc=0x100, mem_ack on the first REQ cycle, beats 0xA0..0xA3.
  - mem_addr=0x100; stall high 6 cycles; then instruction=0xA0.
  - pc=0x10C then gives instruction=0xA3 with stall=0; miss_count=1.
- Delayed ack and gappy beats.
  - Hold mem_ack low 3 cycles; insert 2 idle cycles between beats 1 and 2.
  - Required: stall stays high throughout, mem_req stays high until ack, line data is correct, miss_count=1.
- Conflict eviction. Fill pc=0x000, then pc=0x100 (same index with LINES=16, WORDS=4).
  - Required: the second access misses; a return to 0x000 misses again; miss_count=3.
- Flush in IDLE. Pulse flush after the line at 0x100 is filled.
  - Required: the next access to 0x100 misses; stall=1.
- Flush mid-REFILL. Pulse flush after beat 1 of a refill.
  - Required: all 4 beats are consumed; stall is released; the immediate re-lookup misses and re-requests 0x100.
- Reset mid-REFILL. Drive rst=0 after beat 2.
  - Required: same cycle stall=0, mem_req=0, miss_count=0.
  - After release, pc=0x100 misses.
